// File: rtl/easyaxi_run_ctrl.sv
// Run controller for EASYAXI_TOP: sequences DUT reset, warm-up, a watchdog-bounded
// run and a drain window, then latches the run result until the next start.
module easyaxi_run_ctrl #(
  parameter int unsigned ERR_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYC     = 1,
  parameter int unsigned WARMUP_CYC  = 5,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned DRAIN_CYC   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ERR_W-1:0] err_i,
  input  logic             done_i,
  output logic             dut_rst_n,
  output logic             enable,
  output logic [2:0]       state,
  output logic             finished,
  output logic             pass,
  output logic [1:0]       result,
  output logic [ERR_W-1:0] err_cap,
  output logic [CNT_W-1:0] run_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_WARMUP  = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_END     = 3'd5
  } state_e;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_ERROR   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] WARMUP_LAST  = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [1:0]         result_q, result_d;
  logic [ERR_W-1:0]   err_cap_q, err_cap_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   run_cnt_inc;
  logic               enable_q, enable_d;
  logic               dut_rst_n_q, dut_rst_n_d;
  logic               finished_q, finished_d;
  logic               pass_q, pass_d;

  // Next-state, status update, and output values decoded from the next state.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    result_d  = result_q;
    err_cap_d = err_cap_q;
    run_cnt_d = run_cnt_q;

    if (&run_cnt_q) begin
      run_cnt_inc = run_cnt_q;
    end else begin
      run_cnt_inc = run_cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE, S_END: begin
        if (start) begin
          state_d   = S_DUT_RST;
          phase_d   = '0;
          result_d  = RES_NONE;
          err_cap_d = '0;
          run_cnt_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_DUT_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = S_WARMUP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      S_WARMUP: begin
        run_cnt_d = '0;
        if (phase_q == WARMUP_LAST) begin
          state_d = S_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // The terminating cycle is counted too, so a timeout leaves run_cnt == TIMEOUT_CYC.
        run_cnt_d = run_cnt_inc;
        err_cap_d = err_cap_q | err_i;
        if (|err_i) begin
          state_d  = S_DRAIN;
          phase_d  = '0;
          result_d = RES_ERROR;
        end else if (done_i) begin
          state_d  = S_DRAIN;
          phase_d  = '0;
          result_d = RES_PASS;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          state_d  = S_DRAIN;
          phase_d  = '0;
          result_d = RES_TIMEOUT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        err_cap_d = err_cap_q | err_i;
        if (phase_q == DRAIN_LAST) begin
          state_d = S_END;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    enable_d    = (state_d == S_RUN);
    dut_rst_n_d = !((state_d == S_IDLE) || (state_d == S_DUT_RST));
    finished_d  = (state_d == S_END);
    pass_d      = finished_d && (result_d == RES_PASS);
  end

  // State and registered outputs; synchronous reset returns every output to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      result_q    <= RES_NONE;
      err_cap_q   <= '0;
      run_cnt_q   <= '0;
      enable_q    <= 1'b0;
      dut_rst_n_q <= 1'b0;
      finished_q  <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      result_q    <= result_d;
      err_cap_q   <= err_cap_d;
      run_cnt_q   <= run_cnt_d;
      enable_q    <= enable_d;
      dut_rst_n_q <= dut_rst_n_d;
      finished_q  <= finished_d;
      pass_q      <= pass_d;
    end
  end

  assign state     = state_q;
  assign result    = result_q;
  assign err_cap   = err_cap_q;
  assign run_cnt   = run_cnt_q;
  assign enable    = enable_q;
  assign dut_rst_n = dut_rst_n_q;
  assign finished  = finished_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_easyaxi_run_ctrl.sv
// Bench for easyaxi_run_ctrl: fixed vector table, directed run scenarios, and random
// stimulus against an elapsed-time reference model.
module tb_easyaxi_run_ctrl;

  localparam int R  = 1;
  localparam int W  = 5;
  localparam int TO = 50;
  localparam int D  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  err_i = 4'd0;
  logic        done_i = 1'b0;
  logic        dut_rst_n;
  logic        enable;
  logic [2:0]  state;
  logic        finished;
  logic        pass;
  logic [1:0]  result;
  logic [3:0]  err_cap;
  logic [15:0] run_cnt;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;

  // Reference model: time since the accepted start, and the time the run ended.
  bit         m_started = 1'b0;
  int         m_t = 0;
  int         m_term = -1;
  logic [1:0] m_result = 2'd0;
  logic [3:0] m_errcap = 4'd0;

  easyaxi_run_ctrl #(
    .ERR_W(4), .CNT_W(16), .RST_CYC(R), .WARMUP_CYC(W), .TIMEOUT_CYC(TO), .DRAIN_CYC(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .err_i(err_i), .done_i(done_i),
    .dut_rst_n(dut_rst_n), .enable(enable), .state(state), .finished(finished),
    .pass(pass), .result(result), .err_cap(err_cap), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_state();
    if (!m_started) return 3'd0;
    if (m_t < R) return 3'd1;
    if (m_t < R + W) return 3'd2;
    if (m_term < 0) return 3'd3;
    if (m_t - m_term < D) return 3'd4;
    return 3'd5;
  endfunction

  function automatic logic [15:0] m_runcnt();
    if (!m_started || m_t < R + W) return 16'd0;
    if (m_term < 0) return 16'(m_t - R - W);
    return 16'(m_term - R - W);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [3:0] e, input logic d);
    logic [2:0] ms;
    int k;
    if (r) begin
      m_started = 1'b0; m_t = 0; m_term = -1; m_result = 2'd0; m_errcap = 4'd0;
    end else begin
      ms = m_state();
      if (ms == 3'd0 || ms == 3'd5) begin
        if (s) begin
          m_started = 1'b1; m_t = 0; m_term = -1; m_result = 2'd0; m_errcap = 4'd0;
        end
      end else begin
        if (ms == 3'd3 || ms == 3'd4) m_errcap = m_errcap | e;
        if (ms == 3'd3) begin
          k = m_t - R - W;
          if (e != 4'd0) begin
            m_result = 2'd2; m_term = m_t + 1;
          end else if (d) begin
            m_result = 2'd1; m_term = m_t + 1;
          end else if (k == TO - 1) begin
            m_result = 2'd3; m_term = m_t + 1;
          end
        end
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] e, input logic d);
    logic [2:0] ms;
    logic fin_m;
    rst = r; start = s; err_i = e; done_i = d;
    model_step(r, s, e, d);
    @(posedge clk);
    #1;
    if (enable === 1'b1) en_cnt++;
    ms = m_state();
    fin_m = (ms == 3'd5);
    chk("m_state", 32'(state), 32'(ms));
    chk("m_enable", 32'(enable), 32'(ms == 3'd3));
    chk("m_dut_rst_n", 32'(dut_rst_n), 32'(ms >= 3'd2));
    chk("m_finished", 32'(finished), 32'(fin_m));
    chk("m_pass", 32'(pass), 32'(fin_m && (m_result == 2'd1)));
    chk("m_result", 32'(result), 32'(m_result));
    chk("m_err_cap", 32'(err_cap), 32'(m_errcap));
    chk("m_run_cnt", 32'(run_cnt), 32'(m_runcnt()));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wait_run_cnt(input int n);
    int i = 0;
    while (!(state == 3'd3 && run_cnt == 16'(n)) && i < 200) begin
      idle();
      i++;
    end
    chk("reach_run_state", 32'(state), 32'd3);
    chk("reach_run_cnt", 32'(run_cnt), 32'(n));
  endtask

  task automatic wait_fin(output int n);
    n = 0;
    while (finished !== 1'b1 && n < 200) begin
      idle();
      n++;
    end
    chk("reach_finished", 32'(finished), 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  err;
    logic        done;
    logic [2:0]  st;
    logic        en;
    logic        rn;
    logic [1:0]  res;
    logic        fin;
    logic [3:0]  cap;
    logic [15:0] rc;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n;
    // rst start err done | state en rst_n result fin err_cap run_cnt
    vt[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[3]  = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[6]  = '{1'b0, 1'b1, 4'h3, 1'b1, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd3, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 16'd0};
    vt[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd3, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 16'd1};
    vt[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 16'd2};
    vt[12] = '{1'b0, 1'b0, 4'h2, 1'b0, 3'd4, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2, 16'd2};
    vt[13] = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd4, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2, 16'd2};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst, vt[i].start, vt[i].err, vt[i].done);
      chk("vec_state", 32'(state), 32'(vt[i].st));
      chk("vec_enable", 32'(enable), 32'(vt[i].en));
      chk("vec_dut_rst_n", 32'(dut_rst_n), 32'(vt[i].rn));
      chk("vec_result", 32'(result), 32'(vt[i].res));
      chk("vec_finished", 32'(finished), 32'(vt[i].fin));
      chk("vec_err_cap", 32'(err_cap), 32'(vt[i].cap));
      chk("vec_run_cnt", 32'(run_cnt), 32'(vt[i].rc));
    end
    wait_fin(n);
    chk("vec_end_pass", 32'(pass), 32'd1);

    // Pass run, launched from END (also checks restart clearing of a non-zero err_cap).
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("restart_result", 32'(result), 32'd0);
    chk("restart_err_cap", 32'(err_cap), 32'd0);
    en_cnt = 0;
    wait_run_cnt(9);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    wait_fin(n);
    chk("pass_drain_len", 32'(n), 32'(D));
    chk("pass_enable_cycles", 32'(en_cnt), 32'd10);
    chk("pass_finished", 32'(finished), 32'd1);
    chk("pass_pass", 32'(pass), 32'd1);
    chk("pass_result", 32'(result), 32'd1);
    chk("pass_run_cnt", 32'(run_cnt), 32'd10);
    chk("pass_err_cap", 32'(err_cap), 32'd0);

    // Error run with a late error in DRAIN that only reaches err_cap.
    step(1'b0, 1'b1, 4'd0, 1'b0);
    wait_run_cnt(3);
    step(1'b0, 1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) idle();
    step(1'b0, 1'b0, 4'b0001, 1'b0);
    wait_fin(n);
    chk("err_result", 32'(result), 32'd2);
    chk("err_err_cap", 32'(err_cap), 32'b0101);
    chk("err_pass", 32'(pass), 32'd0);
    chk("err_run_cnt", 32'(run_cnt), 32'd4);

    // Timeout: nothing terminates the run.
    step(1'b0, 1'b1, 4'd0, 1'b0);
    en_cnt = 0;
    wait_fin(n);
    chk("to_enable_cycles", 32'(en_cnt), 32'(TO));
    chk("to_result", 32'(result), 32'd3);
    chk("to_run_cnt", 32'(run_cnt), 32'(TO));

    // Error beats done in the same cycle; start during DRAIN is ignored.
    step(1'b0, 1'b1, 4'd0, 1'b0);
    wait_run_cnt(2);
    step(1'b0, 1'b0, 4'b1000, 1'b1);
    chk("prio_result", 32'(result), 32'd2);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("drain_start_state", 32'(state), 32'd4);
    wait_fin(n);
    chk("prio_final_result", 32'(result), 32'd2);
    chk("prio_err_cap", 32'(err_cap), 32'b1000);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("end_start_state", 32'(state), 32'd1);
    chk("end_start_result", 32'(result), 32'd0);
    chk("end_start_err_cap", 32'(err_cap), 32'd0);

    // Reset in the middle of RUN.
    wait_run_cnt(7);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_dut_rst_n", 32'(dut_rst_n), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_run_cnt", 32'(run_cnt), 32'd0);

    // Reset hold with random inputs, then random traffic against the model.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic s;
      logic d;
      logic [3:0] e;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      d = ($urandom_range(0, 29) == 0);
      step(r, s, e, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/easyaxi_run_ctrl.md
# easyaxi_run_ctrl

Parametrised, synthesizable run controller for the EASYAXI top-level. It sequences DUT reset release and a warm-up window, then asserts `enable`. It watches a configurable vector of error flags plus a done flag, enforces a run-length watchdog and holds a drain window before reporting. Status is latched for the bench or an on-chip status register. It sits between the clock/reset source and `EASYAXI_TOP`, driving that block's `rst_n` and `enable`.

## Interface
Parameters:
- `ERR_W`, 4, number of independent error inputs
- `CNT_W`, 16, width of run-cycle counter and phase counter
- `RST_CYC`, 1, cycles DUT reset is held after `start` (≥1)
- `WARMUP_CYC`, 5, cycles between DUT reset release and `enable` (≥1)
- `TIMEOUT_CYC`, 1000, maximum RUN cycles (≥1, < 2^CNT_W)
- `DRAIN_CYC`, 20, cycles held with `enable`=0 before reporting (≥1)

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: launch a run; sampled only in IDLE or END
- `err_i` in ERR_W: per-channel error flags from the DUT master(s); level
- `done_i` in 1: DUT reports test complete; level
- `dut_rst_n` out 1: active-low reset to the DUT
- `enable` out 1: traffic enable to the DUT
- `state` out 3: FSM state encoding (IDLE=0, DUT_RST=1, WARMUP=2, RUN=3, DRAIN=4, END=5)
- `finished` out 1: high in END
- `pass` out 1: `finished` AND `result`==PASS
- `result` out 2: 0 NONE, 1 PASS, 2 ERROR, 3 TIMEOUT
- `err_cap` out ERR_W: sticky OR of `err_i` seen in RUN and DRAIN
- `run_cnt` out CNT_W: RUN cycles of the last/current run

## Operation
- FSM is Moore. `enable`=1 only in RUN. `dut_rst_n`=0 in IDLE and DUT_RST, and 1 in all other states. All outputs are flops.
- IDLE, `start`=1 → DUT_RST. `result`, `err_cap`, `run_cnt` and the phase counter are cleared.
- DUT_RST: stay RST_CYC cycles → WARMUP.
- WARMUP: stay WARMUP_CYC cycles → RUN. `run_cnt` is 0 on entry.
- RUN: `run_cnt` increments every RUN cycle, including the terminating one, and saturates at all-ones. Exit conditions, evaluated in one cycle with priority error > done > timeout:
  - any `err_i` bit =1 → `result`=ERROR, DRAIN.
  - else `done_i`=1 → `result`=PASS, DRAIN.
  - else `run_cnt`==TIMEOUT_CYC−1 → `result`=TIMEOUT, DRAIN.
- DRAIN: stay DRAIN_CYC cycles → END. `err_cap` keeps OR-ing `err_i`. `result` is not changed by late errors.
- END: hold all status. `start`=1 → DUT_RST with the same clearing as IDLE.
- `start` in DUT_RST, WARMUP, RUN or DRAIN is ignored.
- `err_i` and `done_i` are ignored outside RUN, except `err_cap` accumulation in DRAIN.

## Timing
- Reset values: `state`=IDLE, `dut_rst_n`=0, `enable`=0, `finished`=0, `pass`=0, `result`=0, `err_cap`=0, `run_cnt`=0.
- `rst` asserted mid-run returns every output to its reset value on the next rising edge. This drops `enable` and asserts DUT reset without passing through DRAIN.
- `start` sampled high at edge E0:
  - `dut_rst_n` stays/is 0 for edges E0..E0+RST_CYC.
  - `dut_rst_n` rises after edge E0+RST_CYC.
  - `enable` rises after edge E0+RST_CYC+WARMUP_CYC. With defaults this is 6 cycles after E0.
- Terminating condition sampled at RUN edge Et:
  - `enable` falls after Et.
  - `finished` rises after Et+DRAIN_CYC.
- Timeout gives `enable` high for exactly TIMEOUT_CYC cycles; final `run_cnt`=TIMEOUT_CYC.
- `err_i` and `done_i` high in the same cycle → ERROR. `done_i` in the timeout cycle → PASS.
- Inputs are assumed synchronous to `clk`; no internal synchronisers.

## Test plan
- Reset hold:
  - Stimulus: `rst`=1 for 3 cycles, random `start`/`err_i`/`done_i`.
  - Required: all outputs at reset values, `state`=0.
- Pass run:
  - Stimulus: defaults; `start` pulse; `done_i`=1 on RUN cycle with `run_cnt`=9.
  - Required: `enable` high 10 cycles; 20 cycles later `finished`=1, `pass`=1, `result`=1, `run_cnt`=10, `err_cap`=0.
- Error run:
  - Stimulus: `err_i`=4'b0100 at `run_cnt`=3; `err_i`=4'b0001 during DRAIN cycle 5.
  - Required: `result`=2, `err_cap`=4'b0101, `pass`=0, `run_cnt`=4.
- Timeout:
  - Stimulus: TIMEOUT_CYC=50, no done/error.
  - Required: `enable` high exactly 50 cycles; `result`=3, `run_cnt`=50.
- Priority and ignore:
  - Stimulus: `err_i`=4'b1000 and `done_i`=1 in the same cycle; then a `start` pulse during DRAIN.
  - Required: `result`=2; the `start` in DRAIN has no effect.
  - Stimulus: `start` in END.
  - Required: restarts with `result`=0, `err_cap`=0.
- Mid-run reset:
  - Stimulus: `rst` at RUN cycle 7.
  - Required: next edge `enable`=0, `dut_rst_n`=0, `state`=IDLE, `run_cnt`=0.
